// File: rtl/matmul_pkg.sv
// Shared types, sizes and constant operand tables for the 3x3 matrix multiplier.
// MATMUL_SATURATE_EN selects saturating accumulation; the bounds live here.
package matmul_pkg;

  localparam int unsigned N_DEF  = 3;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned RW_DEF = 16;
  localparam int unsigned AW     = $clog2(N_DEF * N_DEF);

  typedef enum logic [2:0] {StIdle, StClr, StMac, StStore, StFin} state_e;

  typedef logic signed [DW_DEF-1:0] elem_t;
  typedef logic signed [RW_DEF-1:0] result_t;
  typedef logic        [AW-1:0]     addr_t;

  localparam elem_t A_TAB0 [N_DEF*N_DEF] = '{
    8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd9
  };
  localparam elem_t B_TAB0 [N_DEF*N_DEF] = '{
    8'sd9, 8'sd8, 8'sd7, 8'sd6, 8'sd5, 8'sd4, 8'sd3, 8'sd2, 8'sd1
  };
  localparam elem_t STRESS_VAL = 8'sd127;

  localparam result_t SAT_MAX = 16'sh7fff;
  localparam result_t SAT_MIN = 16'sh8000;

  // Table select 1 fills every element with the largest positive value.
  function automatic elem_t a_rom(input int unsigned sel, input addr_t idx);
    return (sel == 1) ? STRESS_VAL : A_TAB0[idx];
  endfunction

  function automatic elem_t b_rom(input int unsigned sel, input addr_t idx);
    return (sel == 1) ? STRESS_VAL : B_TAB0[idx];
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate with synchronous clear.
// With MATMUL_SATURATE_EN defined each add clamps to the result range instead of wrapping.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [RW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [RW-1:0]   prod_ext;
  logic signed [RW-1:0]   acc_d;

  assign prod     = a * b;
  assign prod_ext = RW'(prod);

`ifdef MATMUL_SATURATE_EN
  logic [RW:0] sum;

  // One guard bit: overflow when the top two bits disagree.
  assign sum = {acc[RW-1], acc} + {prod_ext[RW-1], prod_ext};

  always_comb begin
    acc_d = sum[RW-1:0];
    if (sum[RW] != sum[RW-1]) begin
      acc_d = sum[RW] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  always_comb begin
    acc_d = acc + prod_ext;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_d;
    end
  end

endmodule

// File: rtl/matmul_top.sv
// 3x3 signed matrix multiplier over constant ROMs; streams C row-major on Results.
// Accumulation mode is chosen by MATMUL_SATURATE_EN inside matmul_mac.
module matmul_top
  import matmul_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned RW      = RW_DEF,
  parameter int unsigned MAT_SEL = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 START_CONTROLLER,
  output logic                 DONE,
  output logic signed [RW-1:0] Results
);

  localparam int unsigned    CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_e               state;
  logic [CW-1:0]        i, j, k;
  addr_t                a_addr, b_addr, c_addr, rd_idx;
  logic signed [DW-1:0] a_val, b_val;
  logic signed [RW-1:0] acc;
  logic signed [RW-1:0] c_mem [N*N];

  assign a_addr = addr_t'(N) * addr_t'(i) + addr_t'(k);
  assign b_addr = addr_t'(N) * addr_t'(k) + addr_t'(j);
  assign c_addr = addr_t'(N) * addr_t'(i) + addr_t'(j);
  assign a_val  = a_rom(MAT_SEL, a_addr);
  assign b_val  = b_rom(MAT_SEL, b_addr);

  matmul_mac #(
    .DW (DW),
    .RW (RW)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (state == StClr),
    .en  (state == StMac),
    .a   (a_val),
    .b   (b_val),
    .acc (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      rd_idx  <= '0;
      Results <= '0;
      DONE    <= 1'b0;
      for (int n = 0; n < N * N; n++) begin
        c_mem[n] <= '0;
      end
    end else begin
      unique case (state)
        StIdle: begin
          // Idle/Fin re-read the last stored element, so Results is unchanged.
          Results <= c_mem[rd_idx];
          if (START_CONTROLLER) begin
            state <= StClr;
          end
        end
        StClr: begin
          k     <= '0;
          state <= StMac;
        end
        StMac: begin
          if (k == LAST) begin
            k     <= '0;
            state <= StStore;
          end else begin
            k <= k + CW'(1);
          end
        end
        StStore: begin
          c_mem[c_addr] <= acc;
          Results       <= acc;
          rd_idx        <= c_addr;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i     <= '0;
              DONE  <= 1'b1;
              state <= StFin;
            end else begin
              i     <= i + CW'(1);
              state <= StClr;
            end
          end else begin
            j     <= j + CW'(1);
            state <= StClr;
          end
        end
        StFin: begin
          Results <= c_mem[rd_idx];
          if (!START_CONTROLLER) begin
            DONE  <= 1'b0;
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_top.sv
// Directed bench for matmul_top: both operand tables, start/hold/pulse and mid-run reset.
// Expected overflow value follows MATMUL_SATURATE_EN.
module tb_matmul_top;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               done0, done1;
  logic signed [15:0] res0, res1;

  int checks   = 0;
  int failures = 0;

  localparam int EXP0 [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
`ifdef MATMUL_SATURATE_EN
  localparam int EXP1 = 32767;
`else
  localparam int EXP1 = -17149;
`endif

  always #5 clk = ~clk;

  matmul_top #(
    .MAT_SEL (0)
  ) u_dut0 (
    .clk              (clk),
    .rst              (rst),
    .START_CONTROLLER (start),
    .DONE             (done0),
    .Results          (res0)
  );

  matmul_top #(
    .MAT_SEL (1)
  ) u_dut1 (
    .clk              (clk),
    .rst              (rst),
    .START_CONTROLLER (start),
    .DONE             (done1),
    .Results          (res1)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start one run from Idle; checks every cycle up to and including DONE rising.
  task automatic run(input bit hold, input int prev);
    int last;
    last = prev;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (c % 5 == 0) begin
        last = EXP0[c/5-1];
        check($sformatf("res0_elem%0d", c / 5), res0, last);
        check($sformatf("res1_elem%0d", c / 5), res1, EXP1);
      end else begin
        check($sformatf("res0_hold_c%0d", c), res0, last);
      end
      check($sformatf("done0_c%0d", c), done0, (c == 45) ? 1 : 0);
    end
    check("done1_end", done1, 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #20;
    check("rst_done0", done0, 0);
    check("rst_res0", res0, 0);
    check("rst_res1", res1, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("idle_done0", done0, 0);
    check("idle_res0", res0, 0);

    // Held start: DONE stays up, Results frozen.
    run(1'b1, 0);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      check("fin_hold_done", done0, 1);
      check("fin_hold_res", res0, 90);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("drop_done", done0, 0);
    check("drop_res", res0, 90);

    // One-cycle pulse: identical run, then straight back to Idle.
    run(1'b0, 90);
    @(posedge clk);
    #1;
    check("pulse_done_drop", done0, 0);
    check("pulse_res_held", res0, 90);

    // Reset during element 4.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("midrun_res0", res0, 18);
    #2;
    rst = 1'b1;
    #1;
    check("arst_done0", done0, 0);
    check("arst_res0", res0, 0);
    check("arst_res1", res1, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_done", done0, 0);
    check("post_rst_res", res0, 0);

    run(1'b1, 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("final_done", done0, 0);
    check("final_res", res0, 90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
